// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Raster timing generator for a progressive display. Produces
//               pixel/line counters and the decoded sync, blanking and
//               start-of-frame flags for one pixel clock domain.
//
//   Ports
//     clk        in   pixel clock, rising edge
//     rst        in   synchronous active-high reset (overrides en)
//     en         in   pixel advance enable; when low everything holds
//     hcount     out  current pixel column   [CNT_W]
//     vcount     out  current line           [CNT_W]
//     hsync      out  horizontal sync, active level = H_SYNC_POL
//     vsync      out  vertical sync, active level = V_SYNC_POL
//     hblnk      out  horizontal blanking (hcount >= H_ACTIVE)
//     vblnk      out  vertical blanking (vcount >= V_ACTIVE)
//     frame_cnt  out  frame counter [FRAME_CNT_W], only when the macro
//                     VGA_TIMING_FRAME_CNT_EN is defined
//     sof        out  one-clock pulse on the wrap into (0,0)
//
//   Optional feature macro : VGA_TIMING_FRAME_CNT_EN
//
// Revision    : 1.0  initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE     = 1024,
    parameter int H_TOTAL      = 1344,
    parameter int H_SYNC_START = 1048,
    parameter int H_SYNC_TIME  = 136,
    parameter int V_ACTIVE     = 768,
    parameter int V_TOTAL      = 806,
    parameter int V_SYNC_START = 771,
    parameter int V_SYNC_TIME  = 6,
    parameter bit H_SYNC_POL   = 1'b0,
    parameter bit V_SYNC_POL   = 1'b0,
    parameter int CNT_W        = 11,
    parameter int FRAME_CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic [CNT_W-1:0]       hcount,
    output logic [CNT_W-1:0]       vcount,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   hblnk,
    output logic                   vblnk,
`ifdef VGA_TIMING_FRAME_CNT_EN
    output logic [FRAME_CNT_W-1:0] frame_cnt,
`endif
    output logic                   sof
);

    // ------------------------------------------------------------------------
    // Derived timing constants
    // ------------------------------------------------------------------------
    localparam int c_h_blank_start = H_ACTIVE;
    localparam int c_h_blank_time  = H_TOTAL - H_ACTIVE;
    localparam int c_v_blank_start = V_ACTIVE;
    localparam int c_v_blank_time  = V_TOTAL - V_ACTIVE;
    localparam int c_h_sync_end    = H_SYNC_START + H_SYNC_TIME - 1;
    localparam int c_v_sync_end    = V_SYNC_START + V_SYNC_TIME - 1;

    localparam logic [CNT_W-1:0] c_h_last = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_v_last = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_one    = CNT_W'(1);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------------
    if (H_SYNC_START + H_SYNC_TIME > H_TOTAL) begin : g_chk_h_sync_end
        $fatal(1, "vga_timing_gen: hsync extends past end of line");
    end
    if (H_SYNC_START < H_ACTIVE) begin : g_chk_h_sync_start
        $fatal(1, "vga_timing_gen: hsync starts inside active video");
    end
    if (V_SYNC_START + V_SYNC_TIME > V_TOTAL) begin : g_chk_v_sync_end
        $fatal(1, "vga_timing_gen: vsync extends past end of frame");
    end
    if (V_SYNC_START < V_ACTIVE) begin : g_chk_v_sync_start
        $fatal(1, "vga_timing_gen: vsync starts inside active video");
    end
    if (longint'(H_TOTAL) > (longint'(1) << CNT_W)) begin : g_chk_h_width
        $fatal(1, "vga_timing_gen: H_TOTAL does not fit in CNT_W bits");
    end
    if (longint'(V_TOTAL) > (longint'(1) << CNT_W)) begin : g_chk_v_width
        $fatal(1, "vga_timing_gen: V_TOTAL does not fit in CNT_W bits");
    end
    if (FRAME_CNT_W < 1) begin : g_chk_frame_w
        $fatal(1, "vga_timing_gen: FRAME_CNT_W must be at least 1");
    end

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] r_hcount;
    logic [CNT_W-1:0] r_vcount;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_hblnk;
    logic             r_vblnk;
    logic             r_sof;

    // ------------------------------------------------------------------------
    // Next-state counters
    // A wrap can only happen on an enabled cycle, so a line/frame end that
    // coincides with en=0 simply waits at the last position.
    // ------------------------------------------------------------------------
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic [CNT_W-1:0] w_hcount_nxt;
    logic [CNT_W-1:0] w_vcount_nxt;

    assign w_h_wrap = en && (r_hcount == c_h_last);
    assign w_v_wrap = w_h_wrap && (r_vcount == c_v_last);

    always_comb begin
        w_hcount_nxt = r_hcount;
        w_vcount_nxt = r_vcount;
        if (en) begin
            if (w_h_wrap) begin
                w_hcount_nxt = '0;
            end else begin
                w_hcount_nxt = r_hcount + c_one;
            end
        end
        if (w_h_wrap) begin
            if (w_v_wrap) begin
                w_vcount_nxt = '0;
            end else begin
                w_vcount_nxt = r_vcount + c_one;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Flag decode from the next-state counters, so the registered flags line
    // up with the registered counters in the same cycle. With en=0 the next
    // counters equal the current ones and the level flags hold naturally.
    // ------------------------------------------------------------------------
    int   w_hn;
    int   w_vn;
    logic w_hs_act;
    logic w_vs_act;
    logic w_hsync_nxt;
    logic w_vsync_nxt;
    logic w_hblnk_nxt;
    logic w_vblnk_nxt;
    logic w_sof_nxt;

    always_comb begin
        w_hn        = int'(w_hcount_nxt);
        w_vn        = int'(w_vcount_nxt);
        w_hs_act    = (w_hn >= H_SYNC_START) && (w_hn <= c_h_sync_end);
        w_vs_act    = (w_vn >= V_SYNC_START) && (w_vn <= c_v_sync_end);
        w_hsync_nxt = w_hs_act ? H_SYNC_POL : ~H_SYNC_POL;
        w_vsync_nxt = w_vs_act ? V_SYNC_POL : ~V_SYNC_POL;
        w_hblnk_nxt = (w_hn >= c_h_blank_start) &&
                      (w_hn < c_h_blank_start + c_h_blank_time);
        w_vblnk_nxt = (w_vn >= c_v_blank_start) &&
                      (w_vn < c_v_blank_start + c_v_blank_time);
        // Only the enabled frame-wrap cycle produces sof; any later cycle at
        // (0,0), enabled or not, sees w_v_wrap low.
        w_sof_nxt   = w_v_wrap;
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hcount <= '0;
            r_vcount <= '0;
            r_hsync  <= ~H_SYNC_POL;
            r_vsync  <= ~V_SYNC_POL;
            r_hblnk  <= 1'b0;
            r_vblnk  <= 1'b0;
            r_sof    <= 1'b0;
        end else begin
            r_hcount <= w_hcount_nxt;
            r_vcount <= w_vcount_nxt;
            r_hsync  <= w_hsync_nxt;
            r_vsync  <= w_vsync_nxt;
            r_hblnk  <= w_hblnk_nxt;
            r_vblnk  <= w_vblnk_nxt;
            r_sof    <= w_sof_nxt;
        end
    end

    assign hcount = r_hcount;
    assign vcount = r_vcount;
    assign hsync  = r_hsync;
    assign vsync  = r_vsync;
    assign hblnk  = r_hblnk;
    assign vblnk  = r_vblnk;
    assign sof    = r_sof;

`ifdef VGA_TIMING_FRAME_CNT_EN
    // ------------------------------------------------------------------------
    // Frame counter: advances on the same edge that raises sof, so its new
    // value is visible together with the sof pulse.
    // ------------------------------------------------------------------------
    logic [FRAME_CNT_W-1:0] r_frame_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (w_sof_nxt) begin
            r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Self-checking bench for vga_timing_gen. A small-raster
//               instance (12x7, hsync active-high) exercises vectors, frames,
//               gated enable and mid-frame reset; a default-parameter
//               instance is checked over its first line.
// Revision    : 1.0  initial release
// ============================================================================
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    always #5 clk = ~clk;

    // Small instance: H 8 active / 12 total, hsync 9..10 active-high,
    // V 4 active / 7 total, vsync on line 5 active-low. Frame = 84 clks.
    localparam int S_HT = 12;
    localparam int S_VT = 7;
    localparam int S_FRAME = S_HT * S_VT;

    logic [3:0] s_hcount, s_vcount;
    logic       s_hsync, s_vsync, s_hblnk, s_vblnk, s_sof;
    logic [10:0] d_hcount, d_vcount;
    logic        d_hsync, d_vsync, d_hblnk, d_vblnk, d_sof;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [1:0] s_frame_cnt;
    logic [7:0] d_frame_cnt;
`endif

    vga_timing_gen #(
        .H_ACTIVE(8), .H_TOTAL(12), .H_SYNC_START(9), .H_SYNC_TIME(2),
        .V_ACTIVE(4), .V_TOTAL(7), .V_SYNC_START(5), .V_SYNC_TIME(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0), .CNT_W(4), .FRAME_CNT_W(2)
    ) dut_s (
        .clk(clk), .rst(rst), .en(en),
        .hcount(s_hcount), .vcount(s_vcount),
        .hsync(s_hsync), .vsync(s_vsync),
        .hblnk(s_hblnk), .vblnk(s_vblnk),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .frame_cnt(s_frame_cnt),
`endif
        .sof(s_sof)
    );

    vga_timing_gen dut_d (
        .clk(clk), .rst(rst), .en(en),
        .hcount(d_hcount), .vcount(d_vcount),
        .hsync(d_hsync), .vsync(d_vsync),
        .hblnk(d_hblnk), .vblnk(d_vblnk),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .frame_cnt(d_frame_cnt),
`endif
        .sof(d_sof)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
                      name, act, act, exp, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expected small-instance state after k enabled clocks since reset.
    // fresh = the last edge was enabled (sof may only appear then).
    task automatic chk_small(input string tag, input int k, input bit fresh);
        int h, v, hs, vs, hb, vb, sf;
        h  = k % S_HT;
        v  = (k / S_HT) % S_VT;
        hs = (h >= 9 && h <= 10) ? 1 : 0;
        vs = (v == 5) ? 0 : 1;
        hb = (h >= 8) ? 1 : 0;
        vb = (v >= 4) ? 1 : 0;
        sf = (fresh && k > 0 && (k % S_FRAME) == 0) ? 1 : 0;
        chk({tag, " pos"}, int'(s_hcount) * 256 + int'(s_vcount), h * 256 + v);
        chk({tag, " flags{hs,vs,hb,vb,sof}"},
            int'({s_hsync, s_vsync, s_hblnk, s_vblnk, s_sof}),
            (hs << 4) | (vs << 3) | (hb << 2) | (vb << 1) | sf);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk({tag, " frame_cnt"}, int'(s_frame_cnt), (k / S_FRAME) % 4);
`endif
    endtask

    typedef struct {
        logic rst;
        logic en;
        int   h;
        int   v;
        logic hs, vs, hb, vb, sof;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int k;
        int sof_cnt;
        int hs_low;

        // ---------------- Table-driven vectors (small instance) -------------
        vecs[0]  = '{1'b1, 1'b1,  0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1,  1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0,  1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1,  2, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1,  3, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1,  4, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1,  5, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1,  6, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1,  7, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1,  8, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1,  9, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 10, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 11, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 11, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1,  0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b0,  0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 16; i++) begin
            rst = vecs[i].rst;
            en  = vecs[i].en;
            tick();
            chk($sformatf("vec[%0d] pos", i),
                int'(s_hcount) * 256 + int'(s_vcount),
                vecs[i].h * 256 + vecs[i].v);
            chk($sformatf("vec[%0d] flags{hs,vs,hb,vb,sof}", i),
                int'({s_hsync, s_vsync, s_hblnk, s_vblnk, s_sof}),
                int'({vecs[i].hs, vecs[i].vs, vecs[i].hb, vecs[i].vb, vecs[i].sof}));
        end

        // ---------------- Five continuous frames -----------------------------
        rst = 1'b1; en = 1'b1;
        tick();
        k = 0;
        chk_small("frames reset", k, 1'b0);
        rst = 1'b0;
        sof_cnt = 0;
        for (int c = 0; c < 5 * S_FRAME; c++) begin
            tick();
            k++;
            chk_small("frames", k, 1'b1);
            if (s_sof) sof_cnt++;
        end
        chk("frames sof count", sof_cnt, 5);

        // ---------------- Enable every second clock --------------------------
        rst = 1'b1;
        tick();
        k = 0;
        chk_small("half-rate reset", k, 1'b0);
        rst = 1'b0;
        sof_cnt = 0;
        for (int c = 0; c < 4 * S_FRAME + 6; c++) begin
            en = (c % 2 == 0);
            tick();
            if (en) k++;
            chk_small("half-rate", k, en);
            if (s_sof) sof_cnt++;
        end
        chk("half-rate sof clks", sof_cnt, 2);

        // ---------------- Reset mid-frame ------------------------------------
        en = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0;
        k = 0;
        for (int c = 0; c < 41; c++) begin
            tick();
            k++;
        end
        chk_small("pre-reset (5,3)", k, 1'b1);
        rst = 1'b1;
        tick();
        k = 0;
        chk_small("mid-frame reset", k, 1'b0);
        rst = 1'b0;
        sof_cnt = 0;
        for (int c = 0; c < S_FRAME + 6; c++) begin
            tick();
            k++;
            chk_small("after reset", k, 1'b1);
            if (s_sof) sof_cnt++;
        end
        chk("after reset sof count", sof_cnt, 1);

        // ---------------- Default-parameter instance, first line -------------
        rst = 1'b1; en = 1'b1;
        tick();
        chk("default reset pos", int'(d_hcount) * 4096 + int'(d_vcount), 0);
        chk("default reset flags{hs,vs,hb,vb,sof}",
            int'({d_hsync, d_vsync, d_hblnk, d_vblnk, d_sof}), 5'b11000);
        rst = 1'b0;
        hs_low = 0;
        k = 0;
        for (int c = 0; c < 1344 + 4; c++) begin
            int h, v;
            tick();
            k++;
            h = k % 1344;
            v = k / 1344;
            chk("default pos", int'(d_hcount) * 4096 + int'(d_vcount), h * 4096 + v);
            chk("default flags{hs,vs,hb,vb,sof}",
                int'({d_hsync, d_vsync, d_hblnk, d_vblnk, d_sof}),
                int'({(h >= 1048 && h <= 1183) ? 1'b0 : 1'b1, 1'b1,
                      (h >= 1024) ? 1'b1 : 1'b0, 1'b0, 1'b0}));
            if (v == 0 && !d_hsync) hs_low++;
        end
        chk("default hsync width", hs_low, 136);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have these parameters:
- H_ACTIVE, 1024, visible pixels per line.
- H_TOTAL, 1344, clocks per line.
- H_SYNC_START, 1048, first hsync pixel.
- H_SYNC_TIME, 136, hsync width.
- V_ACTIVE, 768, visible lines.
- V_TOTAL, 806, lines per frame.
- V_SYNC_START, 771, first vsync line.
- V_SYNC_TIME, 6, vsync width.
- H_SYNC_POL, 0, hsync active level (0 = active-low).
- V_SYNC_POL, 0, vsync active level (0 = active-low).
- CNT_W, 11, counter width.
- FRAME_CNT_W, 8, frame counter width.

REQ-002 The block SHALL have these ports:
- clk  in  1  pixel clock; one clock domain, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  pixel advance enable.
- hcount  out  CNT_W  current pixel column.
- vcount  out  CNT_W  current line.
- hsync  out  1  horizontal sync, polarity per H_SYNC_POL.
- vsync  out  1  vertical sync, polarity per V_SYNC_POL.
- hblnk  out  1  horizontal blanking.
- vblnk  out  1  vertical blanking.
- sof  out  1  start-of-frame pulse.
- frame_cnt  out  FRAME_CNT_W  frame counter; present only with the macro (REQ-016).

Function
REQ-003 Blanking start and blanking time SHALL be derived from the parameters: H blank start = H_ACTIVE, H blank time = H_TOTAL-H_ACTIVE; the same rule applies vertically.
REQ-004 Elaboration SHALL fail (fatal) if any of these holds: H_SYNC_START+H_SYNC_TIME > H_TOTAL; H_SYNC_START < H_ACTIVE; the vertical equivalent of either; H_TOTAL or V_TOTAL > 2**CNT_W.
REQ-005 When en=1, hcount SHALL increment by 1 per clk; at H_TOTAL-1 it SHALL wrap to 0 on the next enabled cycle.
REQ-006 vcount SHALL increment only on the enabled cycle where hcount wraps; at V_TOTAL-1 it SHALL wrap to 0 on that same cycle.
REQ-007 When en=0, all counters SHALL hold and all level outputs SHALL hold.
REQ-008 All outputs SHALL be driven from flops and SHALL describe the current hcount/vcount values in the same cycle (zero latency between a counter value and its decoded flags); the flags are computed from next-state counter values.
REQ-009 hsync SHALL be at its active level iff H_SYNC_START <= hcount <= H_SYNC_START+H_SYNC_TIME-1.
REQ-010 vsync SHALL be at its active level iff V_SYNC_START <= vcount <= V_SYNC_START+V_SYNC_TIME-1; vsync is independent of hcount.
REQ-011 hblnk=1 iff hcount >= H_ACTIVE; vblnk=1 iff vcount >= V_ACTIVE.
REQ-012 sof SHALL be 1 for exactly one clk: the clk in which the counters enter (0,0) by wrap from (H_TOTAL-1, V_TOTAL-1). It SHALL be 0 in all later clks at (0,0), including clks with en=0.
REQ-013 A line or frame wrap coinciding with en=0 SHALL be deferred until the next enabled cycle; there SHALL be no skipped or doubled counts.

Reset
REQ-014 While rst=1 at a clk edge, the block SHALL load:
- hcount=0, vcount=0.
- hsync=~H_SYNC_POL, vsync=~V_SYNC_POL (inactive).
- hblnk=0, vblnk=0, sof=0.
- frame_cnt=0.
REQ-015 rst SHALL override en. Reset asserted mid-frame SHALL abandon the frame. The first sof after reset release SHALL occur on the first full-frame wrap.

Configuration
REQ-016 With macro VGA_TIMING_FRAME_CNT_EN defined, the frame_cnt port SHALL exist and behave as follows:
- increments by 1 modulo 2**FRAME_CNT_W on each sof clk;
- updates in the same clk as sof;
- resets to 0.
REQ-017 Without VGA_TIMING_FRAME_CNT_EN, the frame_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-018 Reset, then en=1 for 1344 clks -> hcount steps 0..1343 then returns to 0; vcount goes 0->1 on clk 1344.
REQ-019 Defaults, one line -> hsync=0 exactly for hcount 1048..1183 (136 clks); hblnk=1 for hcount 1024..1343.
REQ-020 Run 1083264 enabled clks -> vsync=0 for vcount 771..776; vblnk=1 for vcount 768..805; one single-clk sof at the wrap to (0,0).
REQ-021 en=1 every 2nd clk -> line spans 2688 clks; counters hold on en=0 clks; sof remains 1 clk wide.
REQ-022 rst pulsed at (500,300) with en=1 -> next clk shows (0,0), hsync=vsync=1, hblnk=vblnk=0, sof=0.
REQ-023 Macro defined, FRAME_CNT_W=2, 5 frames -> frame_cnt sequence 1,2,3,0,1, each change aligned with sof.
